// File: rtl/i2c_multi_slave_addr_decoder_pkg.sv
// Shared constants and the decoder state type for the multi-slave I2C
// address decoder.
package i2c_multi_slave_addr_decoder_pkg;

   localparam int I2C_ADDR_WIDTH = 7;
   localparam logic [I2C_ADDR_WIDTH-1:0] I2C_GEN_CALL_ADDR = 7'h00;

   localparam int MAX_NO_OF_SLAVES  = 16;
   localparam int DEF_NO_OF_SLAVES  = 1;
   localparam int DEF_NO_OF_MASTERS = 1;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACK,
      ACTIVE,
      IGNORE
   } i2c_state_e;

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// I2C bus condition detector: synchronises SCL/SDA into the pclk domain
// and produces single-cycle SCL rise/fall strobes and START/STOP strobes.
// Ports:
//   i_clk, i_rst_n      : system clock, synchronous active-low reset
//   i_scl, i_sda        : raw pad lines
//   o_sda               : synchronised SDA, aligned with the strobes
//   o_scl_rise/o_scl_fall : SCL edge strobes
//   o_start/o_stop      : START / STOP condition strobes
module i2c_bus_cond_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_d;
   logic                   r_sda_d;
   logic                   w_scl;
   logic                   w_sda;

   // Lines idle high, so every flop resets to 1 to avoid a false edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
         r_scl_d    <= w_scl;
         r_sda_d    <= w_sda;
      end
   end

   assign w_scl = r_scl_sync[SYNC_STAGES-1];
   assign w_sda = r_sda_sync[SYNC_STAGES-1];

   assign o_sda      = w_sda;
   assign o_scl_rise = w_scl & ~r_scl_d;
   assign o_scl_fall = ~w_scl & r_scl_d;
   // SCL must be high on both samples so an SDA change coinciding with an
   // SCL edge is never mistaken for a bus condition.
   assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_multi_slave_addr_decoder.sv
// Multi-slave I2C address decoder: detects START/Sr/STOP, shifts in the
// address byte, compares it against NO_OF_SLAVES programmable addresses,
// drives the ACK and holds a one-hot slave select until the transaction ends.
// Ports:
//   pclk, areset        : system clock, synchronous active-low reset
//   scl_i, sda_i        : raw pad lines
//   sda_oe              : 1 pulls SDA low (ACK)
//   slave_addr_i        : packed 7-bit addresses, slave k at [7k+6:7k]
//   slave_en_i          : per-slave enable
//   slave_sel_o         : one-hot select (enabled set on general call)
//   rw_o                : R/W bit of the matched address byte
//   addr_match_o        : pulse when a match is ACKed
//   gen_call_o          : general-call transaction active
//   start_o, stop_o     : START/Sr and STOP pulses
//   busy_o              : high from START until STOP
//
// state  | meaning
// IDLE   | bus free, waiting for START
// ADDR   | shifting in the address byte, compare once 8 bits are in
// ACK    | matched; drive ACK for the 9th SCL clock
// ACTIVE | select held, data phase owned by the slave
// IGNORE | not addressed, wait for START/STOP
module i2c_multi_slave_addr_decoder
   import i2c_multi_slave_addr_decoder_pkg::*;
#(
   parameter int NO_OF_SLAVES = DEF_NO_OF_SLAVES,
   parameter int GEN_CALL_EN  = 0,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                                   pclk,
   input  logic                                   areset,
   input  logic                                   scl_i,
   input  logic                                   sda_i,
   output logic                                   sda_oe,
   input  logic [NO_OF_SLAVES*I2C_ADDR_WIDTH-1:0] slave_addr_i,
   input  logic [NO_OF_SLAVES-1:0]                slave_en_i,
   output logic [NO_OF_SLAVES-1:0]                slave_sel_o,
   output logic                                   rw_o,
   output logic                                   addr_match_o,
   output logic                                   gen_call_o,
   output logic                                   start_o,
   output logic                                   stop_o,
   output logic                                   busy_o
);

   logic w_sda;
   logic w_scl_rise;
   logic w_scl_fall;
   logic w_start;
   logic w_stop;

   i2c_bus_cond_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_bus_cond (
      .i_clk      (pclk),
      .i_rst_n    (areset),
      .i_scl      (scl_i),
      .i_sda      (sda_i),
      .o_sda      (w_sda),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_start    (w_start),
      .o_stop     (w_stop)
   );

   i2c_state_e              r_state;
   logic [7:0]              r_shift;
   logic [3:0]              r_bit_cnt;
   logic [NO_OF_SLAVES-1:0] r_sel;
   logic                    r_rw;
   logic                    r_gen_call;
   logic                    r_sda_oe;
   logic                    r_addr_match;
   logic                    r_start;
   logic                    r_stop;
   logic                    r_busy;

   logic [NO_OF_SLAVES-1:0] w_match_vec;
   logic [NO_OF_SLAVES-1:0] w_match_1h;
   logic [NO_OF_SLAVES-1:0] w_sel_next;
   logic                    w_gen_call_hit;
   logic                    w_ack;

   // Address 0x00 is reserved for the general call and never matches a
   // programmed slave address.
   always_comb begin
      w_match_vec = '0;
      for (int k = 0; k < NO_OF_SLAVES; k++) begin
         w_match_vec[k] = slave_en_i[k] &&
                          (r_shift[7:1] != I2C_GEN_CALL_ADDR) &&
                          (slave_addr_i[k*I2C_ADDR_WIDTH +: I2C_ADDR_WIDTH] == r_shift[7:1]);
      end
   end

   // x & -x isolates the lowest set bit: lowest slave index wins.
   assign w_match_1h     = w_match_vec & (~w_match_vec + NO_OF_SLAVES'(1));
   assign w_gen_call_hit = (GEN_CALL_EN != 0) &&
                           (r_shift == {I2C_GEN_CALL_ADDR, 1'b0}) &&
                           (|slave_en_i);
   assign w_sel_next     = w_gen_call_hit ? slave_en_i : w_match_1h;
   assign w_ack          = w_gen_call_hit || (|w_match_vec);

   always_ff @(posedge pclk) begin
      if (!areset) begin
         r_state      <= IDLE;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_sel        <= '0;
         r_rw         <= 1'b0;
         r_gen_call   <= 1'b0;
         r_sda_oe     <= 1'b0;
         r_addr_match <= 1'b0;
         r_start      <= 1'b0;
         r_stop       <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_start      <= 1'b0;
         r_stop       <= 1'b0;
         r_addr_match <= 1'b0;
         if (w_stop) begin
            r_state    <= IDLE;
            r_stop     <= 1'b1;
            r_busy     <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_sel      <= '0;
            r_rw       <= 1'b0;
            r_gen_call <= 1'b0;
            r_sda_oe   <= 1'b0;
         end else if (w_start) begin
            r_state    <= ADDR;
            r_start    <= 1'b1;
            r_busy     <= 1'b1;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_sel      <= '0;
            r_rw       <= 1'b0;
            r_gen_call <= 1'b0;
            r_sda_oe   <= 1'b0;
         end else begin
            case (r_state)
               ADDR: begin
                  // Compare the cycle after the 8th rise; SCL cannot fall
                  // that soon given the oversampling ratio.
                  if (r_bit_cnt == 4'd8) begin
                     if (w_ack) begin
                        r_sel      <= w_sel_next;
                        r_rw       <= r_shift[0];
                        r_gen_call <= w_gen_call_hit;
                        r_state    <= ACK;
                     end else begin
                        r_state    <= IGNORE;
                     end
                  end else if (w_scl_rise) begin
                     r_shift   <= {r_shift[6:0], w_sda};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
               ACK: begin
                  // First fall starts the ACK clock, second fall ends it.
                  if (w_scl_fall) begin
                     if (!r_sda_oe) begin
                        r_sda_oe     <= 1'b1;
                        r_addr_match <= 1'b1;
                     end else begin
                        r_sda_oe <= 1'b0;
                        r_state  <= ACTIVE;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign sda_oe       = r_sda_oe;
   assign slave_sel_o  = r_sel;
   assign rw_o         = r_rw;
   assign addr_match_o = r_addr_match;
   assign gen_call_o   = r_gen_call;
   assign start_o      = r_start;
   assign stop_o       = r_stop;
   assign busy_o       = r_busy;

endmodule

// File: tb/tb_i2c_multi_slave_addr_decoder.sv
module tb_i2c_multi_slave_addr_decoder;

   localparam int H = 8;  // pclk cycles per SCL half period

   typedef struct packed {
      logic       ack;
      logic [1:0] sel;
      logic       rw;
      logic       gen;
   } exp_t;

   typedef struct packed {
      logic [7:0] b;
      logic [6:0] a0;
      logic [6:0] a1;
      logic [1:0] en;
      exp_t       ea;
      exp_t       eb;
   } vec_t;

   logic       pclk = 1'b0;
   logic       areset;
   logic       scl;
   logic       sda;
   logic [6:0] cfg_a0;
   logic [6:0] cfg_a1;
   logic [1:0] cfg_en;
   logic [13:0] w_addr;

   logic       oe_a, rw_a, match_a, gen_a, start_a, stop_a, busy_a;
   logic [1:0] sel_a;
   logic       oe_b, rw_b, match_b, gen_b, start_b, stop_b, busy_b;
   logic [1:0] sel_b;

   int n_checks = 0;
   int n_errors = 0;
   int match_cnt_a = 0, start_cnt_a = 0, stop_cnt_a = 0;
   int match_cnt_b = 0, start_cnt_b = 0, stop_cnt_b = 0;

   assign w_addr = {cfg_a1, cfg_a0};

   always #5 pclk = ~pclk;

   // Instance A: general call enabled; instance B: disabled, deeper sync.
   i2c_multi_slave_addr_decoder #(
      .NO_OF_SLAVES (2), .GEN_CALL_EN (1), .SYNC_STAGES (2)
   ) u_dut_a (
      .pclk (pclk), .areset (areset), .scl_i (scl), .sda_i (sda),
      .sda_oe (oe_a), .slave_addr_i (w_addr), .slave_en_i (cfg_en),
      .slave_sel_o (sel_a), .rw_o (rw_a), .addr_match_o (match_a),
      .gen_call_o (gen_a), .start_o (start_a), .stop_o (stop_a), .busy_o (busy_a)
   );

   i2c_multi_slave_addr_decoder #(
      .NO_OF_SLAVES (2), .GEN_CALL_EN (0), .SYNC_STAGES (3)
   ) u_dut_b (
      .pclk (pclk), .areset (areset), .scl_i (scl), .sda_i (sda),
      .sda_oe (oe_b), .slave_addr_i (w_addr), .slave_en_i (cfg_en),
      .slave_sel_o (sel_b), .rw_o (rw_b), .addr_match_o (match_b),
      .gen_call_o (gen_b), .start_o (start_b), .stop_o (stop_b), .busy_o (busy_b)
   );

   always @(negedge pclk) begin
      if (match_a) match_cnt_a++;
      if (start_a) start_cnt_a++;
      if (stop_a)  stop_cnt_a++;
      if (match_b) match_cnt_b++;
      if (start_b) start_cnt_b++;
      if (stop_b)  stop_cnt_b++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [7:0] b, input logic [6:0] a0,
                                  input logic [6:0] a1, input logic [1:0] en,
                                  input bit gen_en);
      exp_t e;
      logic [6:0] addrs [2];
      e = '0;
      addrs[0] = a0;
      addrs[1] = a1;
      if (b[7:1] == 7'h00) begin
         if (gen_en && !b[0] && en != 2'b00) begin
            e.ack = 1'b1;
            e.sel = en;
            e.gen = 1'b1;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (!e.ack && en[k] && addrs[k] == b[7:1]) begin
               e.ack = 1'b1;
               e.sel = 2'(1 << k);
               e.rw  = b[0];
            end
         end
      end
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic bus_start();
      sda = 1'b0;
      wait_cyc(H);
      scl = 1'b0;
   endtask

   task automatic bus_rstart();
      wait_cyc(H/2); sda = 1'b1;
      wait_cyc(H/2); scl = 1'b1;
      wait_cyc(H/2); sda = 1'b0;
      wait_cyc(H/2); scl = 1'b0;
   endtask

   task automatic bus_stop();
      wait_cyc(H/2); sda = 1'b0;
      wait_cyc(H/2); scl = 1'b1;
      wait_cyc(H);   sda = 1'b1;
      wait_cyc(H);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         wait_cyc(H/2); sda = b[i];
         wait_cyc(H/2); scl = 1'b1;
         wait_cyc(H);   scl = 1'b0;
      end
   endtask

   task automatic addr_phase(input logic [7:0] b, input exp_t ea, input exp_t eb,
                             input bit scramble, input string tag);
      int ma, mb;
      ma = match_cnt_a;
      mb = match_cnt_b;
      send_bits(b, 8);
      wait_cyc(H/2); sda = 1'b1;
      wait_cyc(H/2); scl = 1'b1;
      wait_cyc(H/2);
      chk({tag, " ack9 oe_a"}, int'(oe_a), int'(ea.ack));
      chk({tag, " ack9 oe_b"}, int'(oe_b), int'(eb.ack));
      chk({tag, " sel_a"}, int'(sel_a), int'(ea.sel));
      chk({tag, " sel_b"}, int'(sel_b), int'(eb.sel));
      chk({tag, " rw_a"}, int'(rw_a), int'(ea.rw));
      chk({tag, " rw_b"}, int'(rw_b), int'(eb.rw));
      chk({tag, " gen_a"}, int'(gen_a), int'(ea.gen));
      chk({tag, " gen_b"}, int'(gen_b), 0);
      wait_cyc(H/2); scl = 1'b0;
      if (scramble) begin
         cfg_a0 = 7'($urandom);
         cfg_a1 = 7'($urandom);
         cfg_en = 2'($urandom);
      end
      wait_cyc(H/2);
      chk({tag, " post oe_a"}, int'(oe_a), 0);
      chk({tag, " post oe_b"}, int'(oe_b), 0);
      chk({tag, " hold sel_a"}, int'(sel_a), int'(ea.sel));
      chk({tag, " hold sel_b"}, int'(sel_b), int'(eb.sel));
      chk({tag, " hold gen_a"}, int'(gen_a), int'(ea.gen));
      chk({tag, " match_a pulses"}, match_cnt_a - ma, int'(ea.ack));
      chk({tag, " match_b pulses"}, match_cnt_b - mb, int'(eb.ack));
   endtask

   task automatic run_xact(input logic [7:0] b, input exp_t ea, input exp_t eb,
                           input bit scramble, input string tag);
      int sa, sb, pa, pb;
      sa = start_cnt_a; sb = start_cnt_b;
      bus_start();
      chk({tag, " start_a"}, start_cnt_a - sa, 1);
      chk({tag, " start_b"}, start_cnt_b - sb, 1);
      chk({tag, " busy_a"}, int'(busy_a), 1);
      addr_phase(b, ea, eb, scramble, tag);
      chk({tag, " busy before stop"}, int'(busy_b), 1);
      pa = stop_cnt_a; pb = stop_cnt_b;
      bus_stop();
      chk({tag, " stop_a"}, stop_cnt_a - pa, 1);
      chk({tag, " stop_b"}, stop_cnt_b - pb, 1);
      chk({tag, " idle busy_a"}, int'(busy_a), 0);
      chk({tag, " idle sel_a"}, int'(sel_a), 0);
      chk({tag, " idle sel_b"}, int'(sel_b), 0);
      chk({tag, " idle gen_a"}, int'(gen_a), 0);
   endtask

   vec_t vecs [9];

   initial begin
      exp_t ea, eb;
      int   sa, pa, ma;
      logic [7:0] b;

      vecs[0] = '{8'hA0, 7'h50, 7'h68, 2'b11, '{1'b1, 2'b01, 1'b0, 1'b0}, '{1'b1, 2'b01, 1'b0, 1'b0}};
      vecs[1] = '{8'hD1, 7'h50, 7'h68, 2'b11, '{1'b1, 2'b10, 1'b1, 1'b0}, '{1'b1, 2'b10, 1'b1, 1'b0}};
      vecs[2] = '{8'h42, 7'h50, 7'h68, 2'b11, '{1'b0, 2'b00, 1'b0, 1'b0}, '{1'b0, 2'b00, 1'b0, 1'b0}};
      vecs[3] = '{8'hA0, 7'h50, 7'h50, 2'b11, '{1'b1, 2'b01, 1'b0, 1'b0}, '{1'b1, 2'b01, 1'b0, 1'b0}};
      vecs[4] = '{8'hA0, 7'h50, 7'h50, 2'b10, '{1'b1, 2'b10, 1'b0, 1'b0}, '{1'b1, 2'b10, 1'b0, 1'b0}};
      vecs[5] = '{8'h00, 7'h50, 7'h68, 2'b11, '{1'b1, 2'b11, 1'b0, 1'b1}, '{1'b0, 2'b00, 1'b0, 1'b0}};
      vecs[6] = '{8'h01, 7'h50, 7'h68, 2'b11, '{1'b0, 2'b00, 1'b0, 1'b0}, '{1'b0, 2'b00, 1'b0, 1'b0}};
      vecs[7] = '{8'hD0, 7'h50, 7'h68, 2'b01, '{1'b0, 2'b00, 1'b0, 1'b0}, '{1'b0, 2'b00, 1'b0, 1'b0}};
      vecs[8] = '{8'hA1, 7'h50, 7'h68, 2'b11, '{1'b1, 2'b01, 1'b1, 1'b0}, '{1'b1, 2'b01, 1'b1, 1'b0}};

      areset = 1'b0;
      scl    = 1'b1;
      sda    = 1'b1;
      cfg_a0 = 7'h50;
      cfg_a1 = 7'h68;
      cfg_en = 2'b11;
      wait_cyc(3);
      chk("reset sel_a", int'(sel_a), 0);
      chk("reset oe_a", int'(oe_a), 0);
      chk("reset busy_a", int'(busy_a), 0);
      chk("reset rw_a", int'(rw_a), 0);
      chk("reset gen_a", int'(gen_a), 0);
      chk("reset pulses_a", int'({start_a, stop_a, match_a}), 0);
      chk("reset sel_b", int'(sel_b), 0);
      areset = 1'b1;
      wait_cyc(4);

      for (int i = 0; i < 9; i++) begin
         cfg_a0 = vecs[i].a0;
         cfg_a1 = vecs[i].a1;
         cfg_en = vecs[i].en;
         run_xact(vecs[i].b, vecs[i].ea, vecs[i].eb, 1'b0, $sformatf("vec%0d", i));
         wait_cyc(4);
      end

      // Repeated START clears the select and re-decodes.
      cfg_a0 = 7'h50; cfg_a1 = 7'h68; cfg_en = 2'b11;
      bus_start();
      addr_phase(8'hD1, '{1'b1, 2'b10, 1'b1, 1'b0}, '{1'b1, 2'b10, 1'b1, 1'b0}, 1'b0, "sr first");
      sa = start_cnt_a;
      bus_rstart();
      chk("sr start_a", start_cnt_a - sa, 1);
      chk("sr sel_a clear", int'(sel_a), 0);
      chk("sr sel_b clear", int'(sel_b), 0);
      chk("sr rw_a clear", int'(rw_a), 0);
      chk("sr busy_a", int'(busy_a), 1);
      addr_phase(8'hA0, '{1'b1, 2'b01, 1'b0, 1'b0}, '{1'b1, 2'b01, 1'b0, 1'b0}, 1'b0, "sr second");
      bus_stop();
      chk("sr stop busy_a", int'(busy_a), 0);
      wait_cyc(4);

      // STOP after four address bits.
      ma = match_cnt_a;
      pa = stop_cnt_a;
      bus_start();
      send_bits(8'hA0, 4);
      bus_stop();
      chk("stop4 stop_a", stop_cnt_a - pa, 1);
      chk("stop4 busy_a", int'(busy_a), 0);
      chk("stop4 sel_a", int'(sel_a), 0);
      chk("stop4 oe_a", int'(oe_a), 0);
      chk("stop4 no match", match_cnt_a - ma, 0);
      wait_cyc(4);
      run_xact(8'hA0, '{1'b1, 2'b01, 1'b0, 1'b0}, '{1'b1, 2'b01, 1'b0, 1'b0}, 1'b0, "after stop4");
      wait_cyc(4);

      // Reset pulse while ACTIVE, then a fresh START decodes normally.
      bus_start();
      addr_phase(8'hA0, '{1'b1, 2'b01, 1'b0, 1'b0}, '{1'b1, 2'b01, 1'b0, 1'b0}, 1'b0, "rst pre");
      areset = 1'b0;
      wait_cyc(1);
      areset = 1'b1;
      chk("rst sel_a", int'(sel_a), 0);
      chk("rst sel_b", int'(sel_b), 0);
      chk("rst busy_a", int'(busy_a), 0);
      chk("rst oe_a", int'(oe_a), 0);
      chk("rst rw_gen_a", int'({rw_a, gen_a}), 0);
      wait_cyc(4);
      sa = start_cnt_a;
      bus_rstart();
      chk("rst restart_a", start_cnt_a - sa, 1);
      chk("rst busy again", int'(busy_a), 1);
      addr_phase(8'hA0, '{1'b1, 2'b01, 1'b0, 1'b0}, '{1'b1, 2'b01, 1'b0, 1'b0}, 1'b0, "rst post");
      bus_stop();
      wait_cyc(4);

      // Randomised transactions against the reference model.
      for (int i = 0; i < 30; i++) begin
         logic [6:0] pick [4];
         logic [6:0] a_sel;
         pick[0] = 7'h50;
         pick[1] = 7'h68;
         pick[2] = 7'h00;
         pick[3] = 7'($urandom);
         cfg_a0 = pick[$urandom_range(0, 3)];
         pick[3] = 7'($urandom);
         cfg_a1 = pick[$urandom_range(0, 3)];
         cfg_en = 2'($urandom);
         case ($urandom_range(0, 3))
            0: a_sel = cfg_a0;
            1: a_sel = cfg_a1;
            2: a_sel = 7'h00;
            default: a_sel = 7'($urandom);
         endcase
         b  = {a_sel, 1'($urandom_range(0, 1))};
         ea = model(b, cfg_a0, cfg_a1, cfg_en, 1'b1);
         eb = model(b, cfg_a0, cfg_a1, cfg_en, 1'b0);
         run_xact(b, ea, eb, 1'b1, $sformatf("rnd%0d b=%02h", i, b));
         wait_cyc(4);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
